// File: rtl/cpu_axi_pkg.sv
// Shared definitions for the CPU-to-AXI3 bridge: size codes, AXI ids,
// FSM state encodings and the write-strobe decode.
package cpu_axi_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int ARID_INST = 0;
  localparam int ARID_DATA = 1;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW_W = 2'd1,
    W_B    = 2'd2
  } wstate_t;

  // Size code 3 is not issued by the core; it falls through to a full word.
  function automatic logic [3:0] wstrb_decode(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: wstrb_decode = 4'b0001 << addr_lo;
      SIZE_HALF: wstrb_decode = 4'b0011 << {addr_lo[1], 1'b0};
      default:   wstrb_decode = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-lane strobe generator for 32-bit single-beat writes.
module axi_wstrb_gen
  import cpu_axi_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  assign wstrb = wstrb_decode(size, addr_lo);

endmodule

// File: rtl/cpu_axi_bridge.sv
// Converts the core's sram-like inst/data ports into one AXI3 master.
// Optional macro AXI_BRIDGE_RAW_CHECK_EN narrows read-after-write blocking to a word-address match.
module cpu_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
)(
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  rstate_t r_state, r_next;
  wstate_t w_state, w_next;

  logic [ID_W-1:0]   ar_id_r;
  logic [ADDR_W-1:0] ar_addr_r;
  logic [1:0]        ar_size_r;
  logic [ADDR_W-1:0] aw_addr_r;
  logic [1:0]        aw_size_r;
  logic [DATA_W-1:0] wdata_r;
  logic [3:0]        wstrb_r;
  logic [3:0]        wstrb_new;

  logic raw_block;
  logic data_rd_go, inst_rd_go, data_wr_go;
  logic r_fire, r_is_data, b_fire;
  logic aw_pend, w_pend;
  logic data_rd_ok, wr_ok, wr_defer;

`ifdef AXI_BRIDGE_RAW_CHECK_EN
  assign raw_block = (w_state != W_IDLE) &&
                     (data_addr[ADDR_W-1:2] == aw_addr_r[ADDR_W-1:2]);
`else
  assign raw_block = (w_state != W_IDLE);
`endif

  assign data_rd_go = (r_state == R_IDLE) & data_req & ~data_wr & ~raw_block;
  assign inst_rd_go = (r_state == R_IDLE) & inst_req & ~inst_wr & ~data_rd_go;
  assign data_wr_go = (w_state == W_IDLE) & data_req & data_wr;

  assign r_fire    = (r_state == R_R) & rvalid;
  assign r_is_data = (rid == ID_W'(ARID_DATA));
  assign b_fire    = (w_state == W_B) & bvalid;

  // ---------------- read FSM ----------------
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= R_IDLE;
    else         r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (data_rd_go | inst_rd_go) r_next = R_AR;
      R_AR:    if (arready) r_next = R_R;
      R_R:     if (rvalid) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arvalid      = (r_state == R_AR);
    rready       = (r_state == R_R);
    inst_addr_ok = inst_rd_go;
    data_addr_ok = data_rd_go | data_wr_go;
  end

  always_ff @(posedge clk) begin
    if (data_rd_go) begin
      ar_id_r   <= ID_W'(ARID_DATA);
      ar_addr_r <= data_addr;
      ar_size_r <= data_size;
    end else if (inst_rd_go) begin
      ar_id_r   <= ID_W'(ARID_INST);
      ar_addr_r <= inst_addr;
      ar_size_r <= inst_size;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_data_ok <= 1'b0;
      data_rd_ok   <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
    end else begin
      inst_data_ok <= r_fire & ~r_is_data;
      data_rd_ok   <= r_fire & r_is_data;
      if (r_fire & r_is_data)  data_rdata <= rdata;
      if (r_fire & ~r_is_data) inst_rdata <= rdata;
    end
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge clk) begin
    if (!resetn) w_state <= W_IDLE;
    else         w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (data_wr_go) w_next = W_AW_W;
      W_AW_W:  if ((~aw_pend | awready) & (~w_pend | wready)) w_next = W_B;
      W_B:     if (bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awvalid = (w_state == W_AW_W) & aw_pend;
    wvalid  = (w_state == W_AW_W) & w_pend;
    bready  = (w_state == W_B);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else if (data_wr_go) begin
      aw_pend <= 1'b1;
      w_pend  <= 1'b1;
    end else begin
      if (awvalid & awready) aw_pend <= 1'b0;
      if (wvalid & wready)   w_pend  <= 1'b0;
    end
  end

  axi_wstrb_gen u_wstrb (
    .size    (data_size),
    .addr_lo (data_addr[1:0]),
    .wstrb   (wstrb_new)
  );

  always_ff @(posedge clk) begin
    if (data_wr_go) begin
      aw_addr_r <= data_addr;
      aw_size_r <= data_size;
      wdata_r   <= data_wdata;
      wstrb_r   <= wstrb_new;
    end
  end

  // A write response colliding with a data-port read response slips one cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ok    <= 1'b0;
      wr_defer <= 1'b0;
    end else begin
      wr_ok    <= (b_fire & ~(r_fire & r_is_data)) | wr_defer;
      wr_defer <= b_fire & r_fire & r_is_data;
    end
  end

  assign data_data_ok = data_rd_ok | wr_ok;

  assign arid    = ar_id_r;
  assign araddr  = ar_addr_r;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, ar_size_r};
  assign arburst = 2'b01;
  assign awid    = ID_W'(ARID_DATA);
  assign awaddr  = aw_addr_r;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, aw_size_r};
  assign awburst = 2'b01;
  assign wdata   = wdata_r;
  assign wstrb   = wstrb_r;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed self-checking bench for cpu_axi_bridge.
module tb_cpu_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready;

  int errs = 0;
  int checks = 0;

  cpu_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    tick(); tick();
    #1;
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
      errs++; $display("FAIL reset_valids: got %b expected 00000", {arvalid, rready, awvalid, wvalid, bready});
    end
    checks++;
    if ({inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok} !== 4'b0) begin
      errs++; $display("FAIL reset_oks: got %b expected 0000", {inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok});
    end
    checks++;
    if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      errs++; $display("FAIL reset_rdata: got %h/%h expected 0/0", inst_rdata, data_rdata);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_inst_read();
    inst_req = 1; inst_addr = 32'hBFC00000; inst_size = 2'd2;
    #1;
    checks++;
    if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
      errs++; $display("FAIL inst_addr_ok: got %b%b expected 10", inst_addr_ok, data_addr_ok);
    end
    tick();
    inst_req = 0; arready = 1;
    #1;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'hBFC00000 || arid !== 4'd0 || arsize !== 3'd2) begin
      errs++; $display("FAIL inst_ar: got v=%b a=%h id=%h s=%h expected 1 bfc00000 0 2", arvalid, araddr, arid, arsize);
    end
    tick();
    arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h3C1D0001;
    #1;
    checks++;
    if (rready !== 1'b1 || arvalid !== 1'b0) begin
      errs++; $display("FAIL inst_rready: got rready=%b arvalid=%b expected 1 0", rready, arvalid);
    end
    tick();
    rvalid = 0;
    #1;
    checks++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3C1D0001 || data_data_ok !== 1'b0) begin
      errs++; $display("FAIL inst_data_ok: got ok=%b rd=%h dok=%b expected 1 3c1d0001 0", inst_data_ok, inst_rdata, data_data_ok);
    end
    tick();
    checks++;
    if (inst_data_ok !== 1'b0) begin
      errs++; $display("FAIL inst_ok_pulse: got %b expected 0", inst_data_ok);
    end
  endtask

  task automatic test_arbitration();
    inst_req = 1; inst_addr = 32'h00000100; inst_size = 2'd2;
    data_req = 1; data_wr = 0; data_addr = 32'h00000200; data_size = 2'd2;
    #1;
    checks++;
    if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
      errs++; $display("FAIL arb_prio: got d=%b i=%b expected 1 0", data_addr_ok, inst_addr_ok);
    end
    tick();
    data_req = 0; arready = 1;
    #1;
    checks++;
    if (arid !== 4'd1 || araddr !== 32'h00000200 || inst_addr_ok !== 1'b0) begin
      errs++; $display("FAIL arb_data_ar: got id=%h a=%h iok=%b expected 1 00000200 0", arid, araddr, inst_addr_ok);
    end
    tick();
    arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'hDEADBEEF;
    tick();
    rvalid = 0;
    #1;
    checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'hDEADBEEF || inst_addr_ok !== 1'b1) begin
      errs++; $display("FAIL arb_data_done: got dok=%b rd=%h iok=%b expected 1 deadbeef 1", data_data_ok, data_rdata, inst_addr_ok);
    end
    tick();
    inst_req = 0; arready = 1;
    #1;
    checks++;
    if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h00000100) begin
      errs++; $display("FAIL arb_inst_ar: got v=%b id=%h a=%h expected 1 0 00000100", arvalid, arid, araddr);
    end
    tick();
    arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h12345678;
    tick();
    rvalid = 0;
    #1;
    checks++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h12345678 || data_data_ok !== 1'b0) begin
      errs++; $display("FAIL arb_inst_done: got ok=%b rd=%h dok=%b expected 1 12345678 0", inst_data_ok, inst_rdata, data_data_ok);
    end
    tick();
  endtask

  task automatic test_byte_write();
    data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h00000803; data_wdata = 32'hAB000000;
    #1;
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errs++; $display("FAIL bw_addr_ok: got %b expected 1", data_addr_ok);
    end
    tick();
    data_req = 0; data_wr = 0; wready = 1;
    #1;
    checks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1 || wstrb !== 4'b1000 || awaddr !== 32'h00000803 ||
        awsize !== 3'd0 || awid !== 4'd1 || wdata !== 32'hAB000000 || wlast !== 1'b1) begin
      errs++; $display("FAIL bw_aw_w: got awv=%b wv=%b strb=%b a=%h s=%h id=%h d=%h expected 1 1 1000 00000803 0 1 ab000000",
                       awvalid, wvalid, wstrb, awaddr, awsize, awid, wdata);
    end
    tick();
    wready = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (awvalid !== 1'b1 || wvalid !== 1'b0) begin
        errs++; $display("FAIL bw_aw_wait: got awv=%b wv=%b expected 1 0", awvalid, wvalid);
      end
      tick();
    end
    awready = 1;
    tick();
    awready = 0;
    checks++;
    if (awvalid !== 1'b0 || bready !== 1'b1 || data_data_ok !== 1'b0) begin
      errs++; $display("FAIL bw_b: got awv=%b bready=%b dok=%b expected 0 1 0", awvalid, bready, data_data_ok);
    end
    bvalid = 1;
    tick();
    bvalid = 0;
    checks++;
    if (data_data_ok !== 1'b1) begin
      errs++; $display("FAIL bw_done: got %b expected 1", data_data_ok);
    end
    tick();
    checks++;
    if (data_data_ok !== 1'b0 || bready !== 1'b0) begin
      errs++; $display("FAIL bw_single: got dok=%b bready=%b expected 0 0", data_data_ok, bready);
    end
  endtask

  task automatic test_wstrb();
    logic [1:0] sz [4] = '{2'd1, 2'd1, 2'd0, 2'd3};
    logic [1:0] lo [4] = '{2'd2, 2'd0, 2'd1, 2'd0};
    logic [3:0] ex [4] = '{4'b1100, 4'b0011, 4'b0010, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      data_req = 1; data_wr = 1; data_size = sz[i]; data_addr = {30'h100, lo[i]}; data_wdata = 32'h0;
      tick();
      data_req = 0; data_wr = 0; awready = 1; wready = 1;
      checks++;
      if (wstrb !== ex[i]) begin
        errs++; $display("FAIL wstrb_%0d: got %b expected %b", i, wstrb, ex[i]);
      end
      tick();
      awready = 0; wready = 0; bvalid = 1;
      tick();
      bvalid = 0;
      tick();
    end
  endtask

  task automatic test_raw();
    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h00001000; data_wdata = 32'h11223344;
    #1;
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errs++; $display("FAIL raw_wr_accept: got %b expected 1", data_addr_ok);
    end
    tick();
    data_wr = 0; data_addr = 32'h00001004;
    #1;
`ifdef AXI_BRIDGE_RAW_CHECK_EN
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errs++; $display("FAIL raw_rd_allowed: got %b expected 1", data_addr_ok);
    end
    tick();
    data_req = 0; arready = 1;
    tick();
    arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h55667788;
    tick();
    rvalid = 0;
    checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'h55667788 || awvalid !== 1'b1) begin
      errs++; $display("FAIL raw_rd_done: got dok=%b rd=%h awv=%b expected 1 55667788 1", data_data_ok, data_rdata, awvalid);
    end
    awready = 1; wready = 1;
    tick();
    awready = 0; wready = 0; bvalid = 1;
    tick();
    bvalid = 0;
    checks++;
    if (data_data_ok !== 1'b1) begin
      errs++; $display("FAIL raw_wr_done: got %b expected 1", data_data_ok);
    end
    tick();
`else
    checks++;
    if (data_addr_ok !== 1'b0) begin
      errs++; $display("FAIL raw_rd_blocked_aw: got %b expected 0", data_addr_ok);
    end
    awready = 1; wready = 1;
    tick();
    awready = 0; wready = 0;
    checks++;
    if (data_addr_ok !== 1'b0 || arvalid !== 1'b0) begin
      errs++; $display("FAIL raw_rd_blocked_b: got aok=%b arv=%b expected 0 0", data_addr_ok, arvalid);
    end
    bvalid = 1;
    tick();
    bvalid = 0;
    checks++;
    if (data_data_ok !== 1'b1 || data_addr_ok !== 1'b1) begin
      errs++; $display("FAIL raw_rd_release: got dok=%b aok=%b expected 1 1", data_data_ok, data_addr_ok);
    end
    tick();
    data_req = 0; arready = 1;
    checks++;
    if (araddr !== 32'h00001004 || arid !== 4'd1) begin
      errs++; $display("FAIL raw_rd_ar: got a=%h id=%h expected 00001004 1", araddr, arid);
    end
    tick();
    arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h55667788;
    tick();
    rvalid = 0;
    checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'h55667788) begin
      errs++; $display("FAIL raw_rd_done: got dok=%b rd=%h expected 1 55667788", data_data_ok, data_rdata);
    end
    tick();
`endif
  endtask

  task automatic test_simul_resp();
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h00002000;
    tick();
    data_wr = 1; data_addr = 32'h00003000; data_wdata = 32'hCAFEF00D;
    #1;
    checks++;
    if (data_addr_ok !== 1'b1 || arvalid !== 1'b1) begin
      errs++; $display("FAIL sim_wr_accept: got aok=%b arv=%b expected 1 1", data_addr_ok, arvalid);
    end
    tick();
    data_req = 0; data_wr = 0; arready = 1; awready = 1; wready = 1;
    tick();
    arready = 0; awready = 0; wready = 0;
    rvalid = 1; rid = 4'd1; rdata = 32'hA5A5A5A5; bvalid = 1;
    #1;
    checks++;
    if (rready !== 1'b1 || bready !== 1'b1) begin
      errs++; $display("FAIL sim_readies: got rready=%b bready=%b expected 1 1", rready, bready);
    end
    tick();
    rvalid = 0; bvalid = 0;
    checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'hA5A5A5A5) begin
      errs++; $display("FAIL sim_rd_first: got dok=%b rd=%h expected 1 a5a5a5a5", data_data_ok, data_rdata);
    end
    tick();
    checks++;
    if (data_data_ok !== 1'b1) begin
      errs++; $display("FAIL sim_wr_second: got %b expected 1", data_data_ok);
    end
    tick();
    checks++;
    if (data_data_ok !== 1'b0) begin
      errs++; $display("FAIL sim_quiet: got %b expected 0", data_data_ok);
    end
  endtask

  task automatic test_reset_mid();
    inst_req = 1; inst_addr = 32'h00000400; inst_size = 2'd2;
    tick();
    inst_req = 0; arready = 1;
    tick();
    arready = 0;
    checks++;
    if (rready !== 1'b1) begin
      errs++; $display("FAIL rst_mid_setup: got rready=%b expected 1", rready);
    end
    resetn = 0; rvalid = 1; rid = 4'd0; rdata = 32'h99999999;
    tick();
    rvalid = 0;
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || inst_data_ok !== 1'b0 || inst_rdata !== 32'h0) begin
      errs++; $display("FAIL rst_mid: got arv=%b rr=%b ok=%b rd=%h expected 0 0 0 0", arvalid, rready, inst_data_ok, inst_rdata);
    end
    resetn = 1;
    tick();
    checks++;
    if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || arvalid !== 1'b0) begin
      errs++; $display("FAIL rst_mid_after: got iok=%b dok=%b arv=%b expected 0 0 0", inst_data_ok, data_data_ok, arvalid);
    end
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_arbitration();
    test_byte_write();
    test_wstrb();
    test_raw();
    test_simul_resp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
